// File: rtl/proc_pkg.sv
// Shared constants, state encoding and opcode decode for the lab processor control unit.
package proc_pkg;

    localparam int unsigned PC_W = 8;
    localparam int unsigned RA_W = 4;
    localparam int unsigned IR_W = 16;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    localparam logic RF_S_ALU = 1'b0;
    localparam logic RF_S_RAM = 1'b1;

    // Codes are shown on the board's hex display, so they are fixed.
    typedef enum logic [3:0] {
        StInit   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StNoop   = 4'd3,
        StLoadA  = 4'd4,
        StLoadB  = 4'd5,
        StStore  = 4'd6,
        StAdd    = 4'd7,
        StSub    = 4'd8,
        StHalt   = 4'd9
    } state_e;

    function automatic state_e op_to_state(input logic [3:0] op);
        state_e st;
        case (op)
            OP_STORE: st = StStore;
            OP_LOAD:  st = StLoadA;
            OP_ADD:   st = StAdd;
            OP_SUB:   st = StSub;
            OP_HALT:  st = StHalt;
            default:  st = StNoop;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/proc_control_unit_if.sv
// Controller-to-datapath bundle: instruction in, strobes/addresses and state code out.
interface proc_control_unit_if
    import proc_pkg::*;
#(
    parameter int unsigned P_PC_W = PC_W,
    parameter int unsigned P_RA_W = RA_W,
    parameter int unsigned P_IR_W = IR_W
);
    logic [P_IR_W-1:0] IR;
    logic              PC_clr;
    logic              PC_up;
    logic              IR_ld;
    logic [P_PC_W-1:0] D_addr;
    logic              D_wr;
    logic              RF_s;
    logic [P_RA_W-1:0] RF_W_addr;
    logic              RF_W_wr;
    logic [P_RA_W-1:0] RF_Ra_addr;
    logic [P_RA_W-1:0] RF_Rb_addr;
    logic [2:0]        ALU_s0;
    logic [3:0]        StateO;

    modport master (
        input  IR,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, StateO
    );

    modport slave (
        output IR,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, StateO
    );
endinterface

// File: rtl/step_sync.sv
// Two-flop synchronizer and falling-edge detector for an active-low step pushbutton.
module step_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic pulse_o
);
    logic [1:0] sync_q;
    logic       prev_q;

    // Reset to "released" so a button held through reset does not fire a step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], btn_ni};
            prev_q <= sync_q[1];
        end
    end

    assign pulse_o = prev_q & ~sync_q[1];
endmodule

// File: rtl/proc_control_unit.sv
// Moore control FSM for the 16-bit lab processor. Define PROC_CTRL_STEP_EN to add the
// single-step pushbutton input (Step) that gates each Fetch.
module proc_control_unit
    import proc_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
`ifdef PROC_CTRL_STEP_EN
    input  logic Step,
`endif
    proc_control_unit_if.master bus
);
    state_e     state_q, state_d;
    logic       fetch_go;
    logic [3:0] opcode;

    assign opcode = bus.IR[15:12];

`ifdef PROC_CTRL_STEP_EN
    step_sync u_step_sync (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .btn_ni  (Step),
        .pulse_o (fetch_go)
    );
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        state_d = StInit;
        case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  state_d = fetch_go ? StDecode : StFetch;
            StDecode: state_d = op_to_state(opcode);
            StNoop:   state_d = StFetch;
            StStore:  state_d = StFetch;
            StLoadA:  state_d = StLoadB;
            StLoadB:  state_d = StFetch;
            StAdd:    state_d = StFetch;
            StSub:    state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StInit;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= StInit;
        else        state_q <= state_d;
    end

    // Outputs follow the current state and IR only; anything not driven below stays 0.
    always_comb begin
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = '0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = RF_S_ALU;
        bus.RF_W_addr  = '0;
        bus.RF_W_wr    = 1'b0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.ALU_s0     = ALU_PASS;
        case (state_q)
            StInit: bus.PC_clr = 1'b1;
            StFetch: begin
                bus.IR_ld = fetch_go;
                bus.PC_up = fetch_go;
            end
            StDecode: begin
                bus.D_addr     = bus.IR[7:0];
                bus.RF_Ra_addr = bus.IR[7:4];
                bus.RF_Rb_addr = bus.IR[3:0];
            end
            StStore: begin
                bus.D_addr     = bus.IR[7:0];
                bus.RF_Ra_addr = bus.IR[11:8];
                bus.ALU_s0     = ALU_PASS;
                bus.D_wr       = 1'b1;
            end
            StLoadA: bus.D_addr = bus.IR[7:0];
            StLoadB: begin
                bus.D_addr    = bus.IR[7:0];
                bus.RF_s      = RF_S_RAM;
                bus.RF_W_addr = bus.IR[11:8];
                bus.RF_W_wr   = 1'b1;
            end
            StAdd, StSub: begin
                bus.RF_Ra_addr = bus.IR[7:4];
                bus.RF_Rb_addr = bus.IR[3:0];
                bus.ALU_s0     = (state_q == StAdd) ? ALU_ADD : ALU_SUB;
                bus.RF_s       = RF_S_ALU;
                bus.RF_W_addr  = bus.IR[11:8];
                bus.RF_W_wr    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.StateO = state_q;
endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench: a per-instruction cycle-trace model feeds an expectation queue that a
// negedge monitor drains against the controller's outputs.
module tb_proc_control_unit;

    logic Clk = 1'b0;
    logic Reset;
`ifdef PROC_CTRL_STEP_EN
    logic Step;
`endif

    always #5 Clk = ~Clk;

    proc_control_unit_if bus ();

    proc_control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
`ifdef PROC_CTRL_STEP_EN
        .Step  (Step),
`endif
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_wr;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } obs_t;

    obs_t        exp_q[$];
    logic [15:0] prog_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        ld_pending = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.st     = bus.StateO;
        o.pc_clr = bus.PC_clr;
        o.pc_up  = bus.PC_up;
        o.ir_ld  = bus.IR_ld;
        o.d_addr = bus.D_addr;
        o.d_wr   = bus.D_wr;
        o.rf_s   = bus.RF_s;
        o.w_addr = bus.RF_W_addr;
        o.w_wr   = bus.RF_W_wr;
        o.ra     = bus.RF_Ra_addr;
        o.rb     = bus.RF_Rb_addr;
        o.alu    = bus.ALU_s0;
        return o;
    endfunction

    function automatic obs_t blank(input logic [3:0] st);
        obs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    // Expected cycle trace of one instruction, from its Fetch up to the next Fetch.
    task automatic model_instr(input logic [15:0] ir, input int halt_cycles);
        obs_t       o;
        logic [3:0] op;
        op = ir[15:12];
        o = blank(4'd1); o.ir_ld = 1'b1; o.pc_up = 1'b1; exp_q.push_back(o);
        o = blank(4'd2); o.d_addr = ir[7:0]; o.ra = ir[7:4]; o.rb = ir[3:0]; exp_q.push_back(o);
        case (op)
            4'd1: begin
                o = blank(4'd6); o.d_addr = ir[7:0]; o.ra = ir[11:8]; o.d_wr = 1'b1;
                exp_q.push_back(o);
            end
            4'd2: begin
                o = blank(4'd4); o.d_addr = ir[7:0]; exp_q.push_back(o);
                o = blank(4'd5); o.d_addr = ir[7:0]; o.rf_s = 1'b1;
                o.w_addr = ir[11:8]; o.w_wr = 1'b1; exp_q.push_back(o);
            end
            4'd3, 4'd4: begin
                o = blank((op == 4'd3) ? 4'd7 : 4'd8);
                o.ra = ir[7:4]; o.rb = ir[3:0]; o.alu = (op == 4'd3) ? 3'd1 : 3'd2;
                o.w_addr = ir[11:8]; o.w_wr = 1'b1; exp_q.push_back(o);
            end
            4'd5: for (int i = 0; i < halt_cycles; i++) exp_q.push_back(blank(4'd9));
            default: exp_q.push_back(blank(4'd3));
        endcase
    endtask

    // Datapath stand-in: IR loads the next program word on an edge where IR_ld was high.
    always @(negedge Clk) ld_pending = bus.IR_ld;
    always @(posedge Clk) begin
        #1;
        if (ld_pending && prog_q.size() > 0) bus.IR = prog_q.pop_front();
    end

    always @(negedge Clk) begin
        obs_t a, e;
        if (exp_q.size() > 0) begin
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL trace t=%0t state_exp=%0d got=%h expected=%h", $time, e.st, a, e);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge Clk); #2;
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic reset_dut();
        Reset = 1'b0;
        exp_q.push_back(blank(4'd0) | 33'(1) << 28);
        exp_q.push_back(blank(4'd0) | 33'(1) << 28);
        drain();
        Reset = 1'b1;
    endtask

    initial begin
        logic [15:0] ir;
        logic [3:0]  op;
        Reset  = 1'b1;
        bus.IR = 16'h0000;
`ifdef PROC_CTRL_STEP_EN
        Step = 1'b1;
`endif
        #1;
`ifndef PROC_CTRL_STEP_EN
        // Phase A: directed plus random program ending in HALT.
        prog_q = '{16'h3412, 16'h2A3C, 16'h1507, 16'hF123, 16'h0000, 16'h4ABC};
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 14));
            if (op >= 4'd5) op = op + 4'd1;
            ir = {op, 12'($urandom)};
            prog_q.push_back(ir);
        end
        prog_q.push_back(16'h5000);
        reset_dut();
        foreach (prog_q[i]) model_instr(prog_q[i], 25);
        drain();

        // Phase B: reset arriving in the middle of an ADD.
        prog_q = '{16'h3412, 16'h2A3C, 16'h5000};
        reset_dut();
        model_instr(16'h3412, 0);
        drain();
        check("pre_abort_state", int'(bus.StateO), 7);
        Reset = 1'b0;
        #1;
        check("abort_state", int'(bus.StateO), 0);
        check("abort_pc_clr", int'(bus.PC_clr), 1);
        check("abort_rf_w_wr", int'(bus.RF_W_wr), 0);
        check("abort_d_wr", int'(bus.D_wr), 0);
        exp_q.push_back(blank(4'd0) | 33'(1) << 28);
        drain();
        Reset = 1'b1;
        model_instr(16'h2A3C, 0);
        model_instr(16'h5000, 5);
        drain();
`else
        begin
            int ld_cnt;
            prog_q = '{16'h3412};
            Reset = 1'b0;
            repeat (2) @(negedge Clk);
            #2 Reset = 1'b1;
            repeat (2) @(negedge Clk);
            for (int i = 0; i < 10; i++) begin
                @(negedge Clk);
                check("step_hold_state", int'(bus.StateO), 1);
                check("step_hold_ir_ld", int'(bus.IR_ld), 0);
            end
            #2 Step = 1'b0;
            ld_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge Clk);
                if (i == 2) #2 Step = 1'b1;
                if (bus.IR_ld) ld_cnt++;
            end
            check("step_ir_ld_count", ld_cnt, 1);
            check("step_wait_state", int'(bus.StateO), 1);
            check("step_wait_pc_up", int'(bus.PC_up), 0);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
